// File: rtl/ras_stack_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ras_stack_ctrl_if
// Description : Request/response bundle between the fetch/branch logic and
//               the return-address stack controller.
//               master : CALL/RET requester (drives i_* requests)
//               slave  : ras_stack_ctrl (drives o_* responses and status)
// Signals     : i_push_req/i_push_addr  CALL push and its return address
//               i_pop_req               RET pop
//               i_err_clr               clear sticky error flags
//               o_ready                 controller can accept a request
//               o_push_ack/o_pop_ack    request accepted this cycle (comb)
//               o_pop_valid/o_pop_addr  popped address, one-cycle pulse
//               o_pc_sel                next-PC mux select (= o_pop_valid)
//               o_sp/o_full/o_empty     occupancy status
//               o_ovf_err/o_unf_err     sticky overflow/underflow flags
// Revision    : 1.0 - initial release
// ============================================================================
interface ras_stack_ctrl_if #(
  parameter int AW   = 16,
  parameter int PTRW = 3
);
  logic            i_push_req;
  logic [AW-1:0]   i_push_addr;
  logic            i_pop_req;
  logic            i_err_clr;
  logic            o_ready;
  logic            o_push_ack;
  logic            o_pop_ack;
  logic            o_pop_valid;
  logic [AW-1:0]   o_pop_addr;
  logic            o_pc_sel;
  logic [PTRW:0]   o_sp;
  logic            o_full;
  logic            o_empty;
  logic            o_ovf_err;
  logic            o_unf_err;

  modport master (
    output i_push_req, i_push_addr, i_pop_req, i_err_clr,
    input  o_ready, o_push_ack, o_pop_ack, o_pop_valid, o_pop_addr,
           o_pc_sel, o_sp, o_full, o_empty, o_ovf_err, o_unf_err
  );

  modport slave (
    input  i_push_req, i_push_addr, i_pop_req, i_err_clr,
    output o_ready, o_push_ack, o_pop_ack, o_pop_valid, o_pop_addr,
           o_pc_sel, o_sp, o_full, o_empty, o_ovf_err, o_unf_err
  );
endinterface
`default_nettype wire

// File: rtl/ras_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ras_stack_ctrl
// Description : Return-address stack controller. Accepts CALL pushes and RET
//               pops, owns the stack pointer and a DEPTH-entry address store,
//               and drives the next-PC mux select. Overflow/underflow are
//               recorded in sticky flags.
// Ports       : clk    rising-edge clock
//               rst_n  asynchronous active-low reset
//               bus    ras_stack_ctrl_if.slave (requests in, status out)
// Revision    : 1.0 - initial release
// ============================================================================
module ras_stack_ctrl #(
  parameter int AW    = 16,
  parameter int DEPTH = 8,
  parameter int PTRW  = 3
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  ras_stack_ctrl_if.slave    bus
);

  localparam logic [1:0]    c_ST_IDLE   = 2'b00;
  localparam logic [1:0]    c_ST_POP_RD = 2'b01;
  localparam logic [PTRW:0] c_SP_FULL   = (PTRW+1)'(DEPTH);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [PTRW:0]   r_sp;
  logic [AW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_pop_addr;
  logic            r_ovf_err;
  logic            r_unf_err;

  logic            w_idle;
  logic            w_full;
  logic            w_empty;
  logic            w_push_ack;
  logic            w_pop_ack;
  logic            w_ovf_set;
  logic            w_unf_set;
  logic [PTRW:0]   w_sp_dec;
  logic [PTRW-1:0] w_top_idx;
  logic [PTRW-1:0] w_wr_idx;
  logic            w_ready;
  logic            w_pop_valid;

  assign w_idle  = (r_state == c_ST_IDLE);
  assign w_full  = (r_sp == c_SP_FULL);
  assign w_empty = (r_sp == '0);

  // Push has priority over a simultaneous pop; requests outside IDLE are
  // simply not acknowledged and do not raise error flags.
  assign w_push_ack = w_idle & bus.i_push_req & ~w_full;
  assign w_pop_ack  = w_idle & bus.i_pop_req & ~bus.i_push_req & ~w_empty;
  assign w_ovf_set  = w_idle & bus.i_push_req & w_full;
  assign w_unf_set  = w_idle & bus.i_pop_req & ~bus.i_push_req & w_empty;

  // Index slices are only used when the gating guarantees 0 <= index < DEPTH.
  assign w_sp_dec  = r_sp - 1'b1;
  assign w_top_idx = w_sp_dec[PTRW-1:0];
  assign w_wr_idx  = r_sp[PTRW-1:0];

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    w_state_nxt = c_ST_IDLE;
    case (r_state)
      c_ST_IDLE:   w_state_nxt = w_pop_ack ? c_ST_POP_RD : c_ST_IDLE;
      c_ST_POP_RD: w_state_nxt = c_ST_IDLE;
      default:     w_state_nxt = c_ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  // The popped address is valid for exactly the single POP_RD cycle.
  always_comb begin
    w_ready     = 1'b0;
    w_pop_valid = 1'b0;
    case (r_state)
      c_ST_IDLE:   w_ready     = 1'b1;
      c_ST_POP_RD: w_pop_valid = 1'b1;
      default:     w_ready     = 1'b0;
    endcase
  end

  // ---- stack pointer, popped address and sticky errors ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp       <= '0;
      r_pop_addr <= '0;
      r_ovf_err  <= 1'b0;
      r_unf_err  <= 1'b0;
    end else begin
      if (w_push_ack) begin
        r_sp <= r_sp + 1'b1;
      end else if (w_pop_ack) begin
        r_sp       <= w_sp_dec;
        r_pop_addr <= r_mem[w_top_idx];
      end
      // A new error event wins over a clear in the same cycle.
      if (w_ovf_set) begin
        r_ovf_err <= 1'b1;
      end else if (bus.i_err_clr) begin
        r_ovf_err <= 1'b0;
      end
      if (w_unf_set) begin
        r_unf_err <= 1'b1;
      end else if (bus.i_err_clr) begin
        r_unf_err <= 1'b0;
      end
    end
  end

  // ---- address store (not reset) ----
  always_ff @(posedge clk) begin
    if (w_push_ack) begin
      r_mem[w_wr_idx] <= bus.i_push_addr;
    end
  end

  assign bus.o_ready     = w_ready;
  assign bus.o_push_ack  = w_push_ack;
  assign bus.o_pop_ack   = w_pop_ack;
  assign bus.o_pop_valid = w_pop_valid;
  assign bus.o_pc_sel    = w_pop_valid;
  assign bus.o_pop_addr  = r_pop_addr;
  assign bus.o_sp        = r_sp;
  assign bus.o_full      = w_full;
  assign bus.o_empty     = w_empty;
  assign bus.o_ovf_err   = r_ovf_err;
  assign bus.o_unf_err   = r_unf_err;

endmodule
`default_nettype wire

// File: tb/tb_ras_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ras_stack_ctrl
// Description : Self-checking bench for ras_stack_ctrl. Directed scenarios
//               followed by randomized traffic, checked against a queue-based
//               model of a LIFO return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ras_stack_ctrl;
  localparam int AW    = 16;
  localparam int DEPTH = 8;
  localparam int PTRW  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ras_stack_ctrl_if #(.AW(AW), .PTRW(PTRW)) bus ();

  ras_stack_ctrl #(.AW(AW), .DEPTH(DEPTH), .PTRW(PTRW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: a queue of stored addresses plus a "busy delivering a pop" bit.
  logic [AW-1:0] q[$];
  bit            m_busy;
  bit            m_ovf;
  bit            m_unf;
  logic [AW-1:0] m_pop_addr;
  bit            e_push_ack;
  bit            e_pop_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_busy     = 1'b0;
    m_ovf      = 1'b0;
    m_unf      = 1'b0;
    m_pop_addr = '0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":sp"},        32'(bus.o_sp),        32'(q.size()));
    chk({tag, ":full"},      32'(bus.o_full),      32'(q.size() == DEPTH));
    chk({tag, ":empty"},     32'(bus.o_empty),     32'(q.size() == 0));
    chk({tag, ":ready"},     32'(bus.o_ready),     32'(!m_busy));
    chk({tag, ":pop_valid"}, 32'(bus.o_pop_valid), 32'(m_busy));
    chk({tag, ":pc_sel"},    32'(bus.o_pc_sel),    32'(m_busy));
    chk({tag, ":pop_addr"},  32'(bus.o_pop_addr),  32'(m_pop_addr));
    chk({tag, ":ovf_err"},   32'(bus.o_ovf_err),   32'(m_ovf));
    chk({tag, ":unf_err"},   32'(bus.o_unf_err),   32'(m_unf));
  endtask

  // Apply a request mid-cycle and check the combinational acknowledges.
  task automatic drive(input string tag, input bit push, input logic [AW-1:0] addr,
                       input bit pop, input bit clr);
    @(negedge clk);
    bus.i_push_req  = push;
    bus.i_push_addr = addr;
    bus.i_pop_req   = pop;
    bus.i_err_clr   = clr;
    #1;
    e_push_ack = !m_busy && push && (q.size() < DEPTH);
    e_pop_ack  = !m_busy && pop && !push && (q.size() != 0);
    chk({tag, ":push_ack"}, 32'(bus.o_push_ack), 32'(e_push_ack));
    chk({tag, ":pop_ack"},  32'(bus.o_pop_ack),  32'(e_pop_ack));
  endtask

  // Let the edge happen, advance the model, check registered state.
  task automatic commit(input string tag, input bit push, input logic [AW-1:0] addr,
                        input bit pop, input bit clr);
    bit was_idle;
    bit was_full;
    bit was_empty;
    was_idle  = !m_busy;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    @(posedge clk);
    #1;
    if (e_push_ack) q.push_back(addr);
    m_busy = e_pop_ack;
    if (e_pop_ack) m_pop_addr = q.pop_back();
    if (was_idle && push && was_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (was_idle && pop && !push && was_empty) m_unf = 1'b1;
    else if (clr) m_unf = 1'b0;
    check_state(tag);
  endtask

  task automatic step(input string tag, input bit push, input logic [AW-1:0] addr,
                      input bit pop, input bit clr);
    drive(tag, push, addr, pop, clr);
    commit(tag, push, addr, pop, clr);
  endtask

  task automatic do_reset(input string tag);
    rst_n           = 1'b0;
    bus.i_push_req  = 1'b0;
    bus.i_push_addr = '0;
    bus.i_pop_req   = 1'b0;
    bus.i_err_clr   = 1'b0;
    model_reset();
    #1;
    check_state(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit p, o, c;
    do_reset("reset");

    // 1: basic push then pop
    step("t1_push", 1'b1, 16'h0100, 1'b0, 1'b0);
    step("t1_idle", 1'b0, 16'h0000, 1'b0, 1'b0);
    step("t1_pop",  1'b0, 16'h0000, 1'b1, 1'b0);
    chk("t1_pop_addr_const", 32'(bus.o_pop_addr), 32'h0100);
    step("t1_done", 1'b0, 16'h0000, 1'b0, 1'b0);

    // 2: fill, overflow, then drain with pop_req held continuously
    for (int i = 0; i < DEPTH; i++) step("t2_fill", 1'b1, AW'(16'h10 + i), 1'b0, 1'b0);
    step("t2_ovf", 1'b1, 16'h0018, 1'b0, 1'b0);
    chk("t2_ovf_const", 32'(bus.o_ovf_err), 32'h1);
    for (int i = 0; i < 2 * DEPTH; i++) step("t2_drain", 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("t2_last_const", 32'(bus.o_pop_addr), 32'h10);
    step("t2_clr", 1'b0, 16'h0000, 1'b0, 1'b1);

    // 3: underflow, clear, set-beats-clear
    step("t3_unf",     1'b0, 16'h0000, 1'b1, 1'b0);
    step("t3_clr",     1'b0, 16'h0000, 1'b0, 1'b1);
    step("t3_unf_clr", 1'b0, 16'h0000, 1'b1, 1'b1);
    step("t3_clr2",    1'b0, 16'h0000, 1'b0, 1'b1);

    // 4: simultaneous push and pop at sp=2
    step("t4_a",    1'b1, 16'hA000, 1'b0, 1'b0);
    step("t4_b",    1'b1, 16'hB000, 1'b0, 1'b0);
    step("t4_both", 1'b1, 16'hC000, 1'b1, 1'b0);
    step("t4_pop",  1'b0, 16'h0000, 1'b1, 1'b0);
    chk("t4_addr_const", 32'(bus.o_pop_addr), 32'hC000);

    // 5: push held across POP_RD
    step("t5_pop",   1'b0, 16'h0000, 1'b1, 1'b0);
    step("t5_hold",  1'b1, 16'hD000, 1'b0, 1'b0);
    step("t5_push",  1'b1, 16'hD000, 1'b0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      p = ($urandom_range(0, 99) < 40);
      o = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 6);
      step("rand", p, AW'($urandom), o, c);
    end

    // 6a: reset during the accepting cycle, before the edge
    do_reset("t6_reset");
    for (int i = 0; i < 4; i++) step("t6_fill", 1'b1, AW'(16'h0200 + i), 1'b0, 1'b0);
    drive("t6_pop", 1'b0, 16'h0000, 1'b1, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_state("t6_async");
    @(posedge clk);
    #1;
    check_state("t6_after_edge");
    bus.i_pop_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 6b: reset while the pop result is being presented
    step("t6b_push", 1'b1, 16'h0300, 1'b0, 1'b0);
    step("t6b_pop",  1'b0, 16'h0000, 1'b1, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_state("t6b_async");
    @(negedge clk);
    bus.i_pop_req = 1'b0;
    rst_n = 1'b1;
    step("t6b_idle", 1'b0, 16'h0000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
